fetch_controller: RTL and testbench
===================================

# fetch_controller

Sequences instruction fetch for the RISC-V core: owns the fetch PC and issues one instruction-memory request at a time over a req/gnt/rvalid handshake. It presents fetched instructions to decode through a registered output slot backed by a one-entry skid buffer, and honours decode stalls. Branch/jump redirects flush queued instructions and cancel the in-flight fetch. It sits between the program-counter logic and instruction memory, ahead of decode.

## Interface
- RESET_PC, 32'h0000_0000, fetch address loaded on reset
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-low reset
- redirect_valid  in  1  branch taken / jump; load redirect_pc
- redirect_pc  in  32  redirect target
- stall  in  1  decode cannot accept inst this cycle
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address, equals fetch_pc
- imem_gnt  in  1  request accepted this cycle
- imem_rvalid  in  1  read data valid, one-cycle pulse
- imem_rdata  in  32  instruction word
- inst_valid  out  1  inst/inst_pc hold a valid instruction
- inst  out  32  instruction to decode
- inst_pc  out  32  address of inst
- fetch_pc  out  32  next address to fetch

## Operation
- States: IDLE, REQ, WAIT, HOLD, DROP.
- Reset (rst=0 at an edge): state=IDLE, fetch_pc=RESET_PC, inst_valid=0, inst=32'h0000_0013 (NOP), inst_pc=0, skid empty, stale-request flag cleared.
- imem_req=1 only in REQ; imem_addr=fetch_pc at all times (combinational).
- "Consume" means inst_valid=1 and stall=0 in that cycle.
- IDLE → REQ unconditionally.
- REQ, gnt=1: latch req_pc=fetch_pc, fetch_pc+=4 (wraps mod 2^32), → WAIT. REQ, gnt=0: stay.
- WAIT, rvalid=1:
  - Slot empty or consumed this cycle: slot loads {rdata, req_pc}, inst_valid=1, → REQ.
  - Otherwise: skid loads the response, → HOLD.
- WAIT, rvalid=0: stay. Slot is consumed independently.
- HOLD: on consume, skid moves into slot (inst_valid stays 1), → REQ. No request is issued in HOLD.
- A consume with no refill clears inst_valid.
- Redirect (highest priority, any state except IDLE):
  - fetch_pc = {redirect_pc[31:2], 2'b00}.
  - inst_valid=0 and skid cleared, even when stalled.
  - Next state:
    - REQ with gnt=0 → REQ.
    - REQ with gnt=1 → DROP; the granted fetch is stale and fetch_pc is not incremented.
    - WAIT with rvalid=0 → DROP.
    - WAIT with rvalid=1 → REQ; the response is discarded.
    - HOLD → REQ.
    - DROP → stays DROP unless rvalid=1, then → REQ.
- DROP: discard the next rvalid, then → REQ. No request is issued in DROP.
- Redirect in IDLE: fetch_pc loads the target; → REQ.
- At most one request outstanding; a response is never lost or duplicated.

## Timing
- Exit reset on cycle 0 (first edge with rst=1): IDLE. imem_req=1 from cycle 1.
- Zero-wait memory (gnt in the REQ cycle, rvalid the next cycle): inst_valid rises the edge after rvalid. Sustained throughput is 1 instruction per 2 cycles.
- Redirect → imem_req with the new address: the next cycle, if nothing is outstanding; otherwise the cycle after the stale rvalid.
- inst, inst_pc and inst_valid are registered. They hold stable while inst_valid=1 and stall=1.
- rst=0 mid-transaction drops any outstanding response. A late rvalid after reset, in IDLE or REQ, is ignored.

## Test plan
- Reset/sequential: RESET_PC=0, gnt tied 1, rvalid one cycle after gnt, rdata=addr → imem_addr 0,4,8,12. inst_valid pulses carry inst_pc=0,4,8 with inst=inst_pc; first inst_valid appears 3 cycles after reset release.
- Stall/skid: hold stall=1 from the first inst_valid (pc 0) for 5 cycles → inst stays 0. The pc-4 response sits in the skid, no request is issued, and after release pc 4 follows on the next cycle with no loss.
- Redirect in WAIT: redirect_pc=0x100 while the fetch of 0x8 is outstanding, rvalid 2 cycles later → 0x8 data is never presented; next imem_addr=0x100; next inst_pc=0x100.
- Redirect coincident with gnt: gnt for 0x10 plus redirect_pc=0x203 in the same cycle → fetch_pc=0x200. The 0x10 response is dropped and the next request is 0x200.
- Grant latency and wrap: gnt delayed 3 cycles, RESET_PC=32'hFFFF_FFFC → imem_req held stable with addr 0xFFFFFFFC; next fetch address is 0x0.
- Mid-fetch reset: rst=0 for one cycle while in WAIT, stale rvalid arrives after release → inst_valid stays 0; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: owns the fetch PC, issues one imem request at a
// time, and feeds decode through a registered slot backed by a one-entry skid.
module fetch_controller #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [31:0] fetch_pc
);

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP      = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_STEP  = 32'd4;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD,
    DROP
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic [XLEN-1:0] skid_inst_q, skid_inst_d;
  logic [XLEN-1:0] skid_pc_q, skid_pc_d;
  logic            inst_valid_q, inst_valid_d;
  logic [XLEN-1:0] inst_q, inst_d;
  logic [XLEN-1:0] inst_pc_q, inst_pc_d;

  logic            consume;
  logic [XLEN-1:0] redirect_target;
  logic            unused_redirect_low;

  assign consume             = inst_valid_q && !stall;
  assign redirect_target     = {redirect_pc[XLEN-1:2], 2'b00};
  assign unused_redirect_low = ^redirect_pc[1:0];

  // State and datapath registers; the skid holds valid data exactly in HOLD.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      fetch_pc_q   <= RESET_PC;
      req_pc_q     <= '0;
      skid_inst_q  <= '0;
      skid_pc_q    <= '0;
      inst_valid_q <= 1'b0;
      inst_q       <= NOP;
      inst_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      req_pc_q     <= req_pc_d;
      skid_inst_q  <= skid_inst_d;
      skid_pc_q    <= skid_pc_d;
      inst_valid_q <= inst_valid_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
    end
  end

  // Next-state and slot/skid updates; redirect overrides the normal flow.
  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    req_pc_d     = req_pc_q;
    skid_inst_d  = skid_inst_q;
    skid_pc_d    = skid_pc_q;
    inst_valid_d = inst_valid_q && !consume;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;

    unique case (state_q)
      IDLE: begin
        state_d = REQ;
        if (redirect_valid) fetch_pc_d = redirect_target;
      end
      REQ: begin
        if (imem_gnt) begin
          req_pc_d   = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + PC_STEP;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          if (!inst_valid_q || consume) begin
            inst_d       = imem_rdata;
            inst_pc_d    = req_pc_q;
            inst_valid_d = 1'b1;
            state_d      = REQ;
          end else begin
            skid_inst_d = imem_rdata;
            skid_pc_d   = req_pc_q;
            state_d     = HOLD;
          end
        end
      end
      HOLD: begin
        if (consume) begin
          inst_d       = skid_inst_q;
          inst_pc_d    = skid_pc_q;
          inst_valid_d = 1'b1;
          state_d      = REQ;
        end
      end
      DROP: begin
        if (imem_rvalid) state_d = REQ;
      end
      default: state_d = IDLE;
    endcase

    // A granted-but-unanswered fetch becomes stale and is swallowed in DROP.
    if (redirect_valid && (state_q != IDLE)) begin
      fetch_pc_d   = redirect_target;
      inst_valid_d = 1'b0;
      unique case (state_q)
        REQ:     state_d = imem_gnt ? DROP : REQ;
        WAIT:    state_d = imem_rvalid ? REQ : DROP;
        HOLD:    state_d = REQ;
        DROP:    state_d = imem_rvalid ? REQ : DROP;
        default: state_d = REQ;
      endcase
    end
  end

  assign imem_req   = (state_q == REQ);
  assign imem_addr  = fetch_pc_q;
  assign fetch_pc   = fetch_pc_q;
  assign inst_valid = inst_valid_q;
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller: inputs driven and outputs sampled on the
// falling edge; a second instance covers a non-zero reset PC.
module tb_fetch_controller;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  logic        imem_req, inst_valid;
  logic [31:0] imem_addr, inst, inst_pc, fetch_pc;
  logic        imem_req_w, inst_valid_w;
  logic [31:0] imem_addr_w, inst_w, inst_pc_w, fetch_pc_w;

  int tests;
  int fails;

  // One-deep memory responder state: a grant seen now is answered next cycle.
  logic        pend;
  logic [31:0] pend_addr;

  fetch_controller dut (
    .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .stall(stall), .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .inst_valid(inst_valid),
    .inst(inst), .inst_pc(inst_pc), .fetch_pc(fetch_pc)
  );

  fetch_controller #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .stall(stall), .imem_req(imem_req_w), .imem_addr(imem_addr_w), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .inst_valid(inst_valid_w),
    .inst(inst_w), .inst_pc(inst_pc_w), .fetch_pc(fetch_pc_w)
  );

  always #5 clk = ~clk;

  task automatic mem_step();
    imem_rvalid = pend;
    imem_rdata  = pend_addr;
    pend        = imem_req && imem_gnt;
    pend_addr   = imem_addr;
  endtask

  task automatic run_auto(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      mem_step();
    end
  endtask

  // Leaves rst released with gnt=1; the next rising edge is cycle 0.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; stall = 1'b0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    pend = 1'b0; pend_addr = '0;
    @(negedge clk);
    rst = 1'b1; imem_gnt = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0; imem_gnt = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    tests++;
    if ({imem_req, inst_valid} !== 2'b00) begin
      fails++; $display("FAIL reset_req_valid: got %b expected 00", {imem_req, inst_valid});
    end
    tests++;
    if (inst !== 32'h0000_0013) begin
      fails++; $display("FAIL reset_inst: got %h expected 00000013", inst);
    end
    tests++;
    if ({inst_pc, fetch_pc, imem_addr} !== 96'h0) begin
      fails++; $display("FAIL reset_pcs: got %h/%h/%h expected 0/0/0", inst_pc, fetch_pc, imem_addr);
    end
    tests++;
    if (fetch_pc_w !== 32'hFFFF_FFFC) begin
      fails++; $display("FAIL reset_pc_param: got %h expected fffffffc", fetch_pc_w);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] e_addr, e_pc;
    logic        e_req, e_vld;
    do_reset();
    for (int n = 0; n < 7; n++) begin
      @(negedge clk);
      e_req  = (n % 2 == 0);
      e_addr = (n % 2 == 0) ? 32'(2 * n) : 32'(2 * n + 2);
      e_vld  = (n >= 2) && (n % 2 == 0);
      e_pc   = 32'(2 * n - 4);
      tests++;
      if ({imem_req, imem_addr} !== {e_req, e_addr}) begin
        fails++; $display("FAIL seq_req[%0d]: got %b/%h expected %b/%h", n, imem_req, imem_addr, e_req, e_addr);
      end
      tests++;
      if (inst_valid !== e_vld) begin
        fails++; $display("FAIL seq_valid[%0d]: got %b expected %b", n, inst_valid, e_vld);
      end
      if (e_vld) begin
        tests++;
        if ({inst_pc, inst} !== {e_pc, e_pc}) begin
          fails++; $display("FAIL seq_inst[%0d]: got %h/%h expected %h/%h", n, inst_pc, inst, e_pc, e_pc);
        end
      end
      mem_step();
    end
  endtask

  task automatic test_stall_skid();
    do_reset();
    run_auto(2);
    for (int n = 2; n <= 10; n++) begin
      @(negedge clk);
      if (n >= 3 && n <= 7) begin
        tests++;
        if ({inst_valid, inst_pc, inst, imem_req} !== {1'b1, 32'h0, 32'h0, 1'b0}) begin
          fails++; $display("FAIL stall_hold[%0d]: got v=%b pc=%h inst=%h req=%b expected v=1 pc=0 inst=0 req=0",
                            n, inst_valid, inst_pc, inst, imem_req);
        end
      end
      if (n == 8) begin
        tests++;
        if ({inst_valid, inst_pc, inst} !== {1'b1, 32'h4, 32'h4}) begin
          fails++; $display("FAIL stall_release: got v=%b pc=%h inst=%h expected v=1 pc=4 inst=4", inst_valid, inst_pc, inst);
        end
        tests++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h8}) begin
          fails++; $display("FAIL stall_next_req: got %b/%h expected 1/00000008", imem_req, imem_addr);
        end
      end
      if (n == 10) begin
        tests++;
        if ({inst_valid, inst_pc, inst} !== {1'b1, 32'h8, 32'h8}) begin
          fails++; $display("FAIL stall_after: got v=%b pc=%h inst=%h expected v=1 pc=8 inst=8", inst_valid, inst_pc, inst);
        end
      end
      stall = (n <= 6);
      mem_step();
    end
    stall = 1'b0;
  endtask

  task automatic test_redirect_wait();
    do_reset();
    run_auto(5);
    @(negedge clk);
    tests++;
    if ({imem_req, imem_addr, inst_valid} !== {1'b0, 32'hC, 1'b0}) begin
      fails++; $display("FAIL rw_wait: got req=%b addr=%h v=%b expected req=0 addr=c v=0", imem_req, imem_addr, inst_valid);
    end
    redirect_valid = 1'b1; redirect_pc = 32'h100; imem_rvalid = 1'b0; pend = 1'b0;
    @(negedge clk);
    redirect_valid = 1'b0;
    tests++;
    if ({imem_req, imem_addr, inst_valid} !== {1'b0, 32'h100, 1'b0}) begin
      fails++; $display("FAIL rw_drop: got req=%b addr=%h v=%b expected req=0 addr=100 v=0", imem_req, imem_addr, inst_valid);
    end
    imem_rvalid = 1'b1; imem_rdata = 32'h8;
    @(negedge clk);
    imem_rvalid = 1'b0;
    tests++;
    if ({imem_req, imem_addr, inst_valid} !== {1'b1, 32'h100, 1'b0}) begin
      fails++; $display("FAIL rw_new_req: got req=%b addr=%h v=%b expected req=1 addr=100 v=0", imem_req, imem_addr, inst_valid);
    end
    mem_step();
    @(negedge clk);
    tests++;
    if (inst_valid !== 1'b0) begin
      fails++; $display("FAIL rw_stale_shown: got v=%b pc=%h expected v=0", inst_valid, inst_pc);
    end
    mem_step();
    @(negedge clk);
    tests++;
    if ({inst_valid, inst_pc, inst} !== {1'b1, 32'h100, 32'h100}) begin
      fails++; $display("FAIL rw_target: got v=%b pc=%h inst=%h expected v=1 pc=100 inst=100", inst_valid, inst_pc, inst);
    end
  endtask

  task automatic test_redirect_gnt();
    do_reset();
    run_auto(8);
    @(negedge clk);
    tests++;
    if ({imem_req, imem_addr, inst_valid, inst_pc} !== {1'b1, 32'h10, 1'b1, 32'hC}) begin
      fails++; $display("FAIL rg_pre: got req=%b addr=%h v=%b pc=%h expected req=1 addr=10 v=1 pc=c",
                        imem_req, imem_addr, inst_valid, inst_pc);
    end
    redirect_valid = 1'b1; redirect_pc = 32'h203;
    mem_step();
    @(negedge clk);
    redirect_valid = 1'b0;
    tests++;
    if ({fetch_pc, imem_req, inst_valid} !== {32'h200, 1'b0, 1'b0}) begin
      fails++; $display("FAIL rg_align: got pc=%h req=%b v=%b expected pc=200 req=0 v=0", fetch_pc, imem_req, inst_valid);
    end
    mem_step();
    @(negedge clk);
    tests++;
    if ({imem_req, imem_addr, inst_valid} !== {1'b1, 32'h200, 1'b0}) begin
      fails++; $display("FAIL rg_new_req: got req=%b addr=%h v=%b expected req=1 addr=200 v=0", imem_req, imem_addr, inst_valid);
    end
    mem_step();
    @(negedge clk);
    tests++;
    if (inst_valid !== 1'b0) begin
      fails++; $display("FAIL rg_stale_shown: got v=%b pc=%h expected v=0", inst_valid, inst_pc);
    end
    mem_step();
    @(negedge clk);
    tests++;
    if ({inst_valid, inst_pc, inst} !== {1'b1, 32'h200, 32'h200}) begin
      fails++; $display("FAIL rg_target: got v=%b pc=%h inst=%h expected v=1 pc=200 inst=200", inst_valid, inst_pc, inst);
    end
  endtask

  task automatic test_grant_wrap();
    do_reset();
    imem_gnt = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      tests++;
      if ({imem_req_w, imem_addr_w} !== {1'b1, 32'hFFFF_FFFC}) begin
        fails++; $display("FAIL wrap_req_hold[%0d]: got %b/%h expected 1/fffffffc", n, imem_req_w, imem_addr_w);
      end
    end
    @(negedge clk);
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt = 1'b0;
    tests++;
    if ({imem_req_w, fetch_pc_w} !== {1'b0, 32'h0}) begin
      fails++; $display("FAIL wrap_pc: got req=%b pc=%h expected req=0 pc=0", imem_req_w, fetch_pc_w);
    end
    imem_rvalid = 1'b1; imem_rdata = 32'hFFFF_FFFC;
    @(negedge clk);
    imem_rvalid = 1'b0;
    tests++;
    if ({inst_valid_w, inst_pc_w, imem_req_w, imem_addr_w} !== {1'b1, 32'hFFFF_FFFC, 1'b1, 32'h0}) begin
      fails++; $display("FAIL wrap_next: got v=%b pc=%h req=%b addr=%h expected v=1 pc=fffffffc req=1 addr=0",
                        inst_valid_w, inst_pc_w, imem_req_w, imem_addr_w);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    run_auto(1);
    @(negedge clk);
    tests++;
    if (imem_req !== 1'b0) begin
      fails++; $display("FAIL mr_wait: got req=%b expected 0", imem_req);
    end
    rst = 1'b0; imem_rvalid = 1'b0; imem_gnt = 1'b0; pend = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    tests++;
    if ({inst_valid, fetch_pc, imem_req} !== {1'b0, 32'h0, 1'b0}) begin
      fails++; $display("FAIL mr_reset: got v=%b pc=%h req=%b expected v=0 pc=0 req=0", inst_valid, fetch_pc, imem_req);
    end
    imem_rvalid = 1'b1; imem_rdata = 32'h0000_0BAD;
    @(negedge clk);
    tests++;
    if ({imem_req, imem_addr, inst_valid} !== {1'b1, 32'h0, 1'b0}) begin
      fails++; $display("FAIL mr_idle_rvalid: got req=%b addr=%h v=%b expected req=1 addr=0 v=0", imem_req, imem_addr, inst_valid);
    end
    @(negedge clk);
    imem_rvalid = 1'b0;
    tests++;
    if ({imem_req, imem_addr, inst_valid} !== {1'b1, 32'h0, 1'b0}) begin
      fails++; $display("FAIL mr_req_rvalid: got req=%b addr=%h v=%b expected req=1 addr=0 v=0", imem_req, imem_addr, inst_valid);
    end
    imem_gnt = 1'b1;
    mem_step();
    @(negedge clk);
    mem_step();
    @(negedge clk);
    tests++;
    if ({inst_valid, inst_pc, inst} !== {1'b1, 32'h0, 32'h0}) begin
      fails++; $display("FAIL mr_restart: got v=%b pc=%h inst=%h expected v=1 pc=0 inst=0", inst_valid, inst_pc, inst);
    end
  endtask

  initial begin
    clk = 1'b0; rst = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; stall = 1'b0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    pend = 1'b0; pend_addr = '0;
    tests = 0; fails = 0;
    test_reset();
    test_sequential();
    test_stall_skid();
    test_redirect_wait();
    test_redirect_gnt();
    test_grant_wrap();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
